// File: rtl/nes_controller_device.sv
// nes_controller_device: controller end of the NES serial pad protocol.
// Snapshots an active-high button vector on latch and shifts it out
// active-low on each console clock rising edge.
//   clk                 system clock
//   i_rst_n             asynchronous active-low reset
//   i_buttons[7:0]      live buttons, bit7=A ... bit0=Right, 1=pressed
//   i_controller_latch  console latch, asynchronous, active-high
//   i_controller_clock  console clock, asynchronous, idles high
//   o_controller_data   serial data, 0=pressed
//   o_latched           pulse when the snapshot is frozen
//   o_frame_done        pulse when the 7th clock rising edge is processed
//   o_busy              high while loading or shifting
module nes_controller_device #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_buttons,
    input  logic       i_controller_latch,
    input  logic       i_controller_clock,
    output logic       o_controller_data,
    output logic       o_latched,
    output logic       o_frame_done,
    output logic       o_busy
);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;
    state_e                 state_q;
    logic [SYNC_STAGES-1:0] l_sync_q, c_sync_q;
    logic                   l_prev_q, c_prev_q;
    logic [7:0]             shreg_q;
    logic [3:0]             bcnt_q;
    logic [TW-1:0]          tcnt_q;
    logic                   data_q, latched_q, frame_done_q, busy_q;
    logic                   l_s, c_s, l_fall, c_rise;
    assign l_s    = l_sync_q[SYNC_STAGES-1];
    assign c_s    = c_sync_q[SYNC_STAGES-1];
    assign l_fall = ~l_s & l_prev_q;
    assign c_rise = c_s & ~c_prev_q;
    assign o_controller_data = data_q;
    assign o_latched         = latched_q;
    assign o_frame_done      = frame_done_q;
    assign o_busy            = busy_q;
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            l_sync_q     <= '0;
            c_sync_q     <= '1;
            l_prev_q     <= 1'b0;
            c_prev_q     <= 1'b1;
            shreg_q      <= 8'h00;
            bcnt_q       <= 4'd0;
            tcnt_q       <= '0;
            data_q       <= 1'b1;
            latched_q    <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            l_sync_q     <= {l_sync_q[SYNC_STAGES-2:0], i_controller_latch};
            c_sync_q     <= {c_sync_q[SYNC_STAGES-2:0], i_controller_clock};
            l_prev_q     <= l_s;
            c_prev_q     <= c_s;
            latched_q    <= 1'b0;
            frame_done_q <= 1'b0;
            // latch high overrides any state and any clock edge; data tracks live buttons
            if (l_s) begin
                state_q <= LOAD;
                shreg_q <= i_buttons;
                data_q  <= ~i_buttons[7];
                bcnt_q  <= 4'd0;
                tcnt_q  <= '0;
                busy_q  <= 1'b1;
            end else if (state_q == LOAD && l_fall) begin
                // a clock edge coinciding with the latch fall is discarded here
                state_q   <= SHIFT;
                bcnt_q    <= 4'd0;
                tcnt_q    <= '0;
                latched_q <= 1'b1;
            end else if (state_q == SHIFT) begin
                if (c_rise) begin
                    // over-read edges shift in 1, so the line reads pressed
                    shreg_q      <= {shreg_q[6:0], 1'b1};
                    data_q       <= ~shreg_q[6];
                    bcnt_q       <= (bcnt_q == 4'd15) ? bcnt_q : bcnt_q + 4'd1;
                    tcnt_q       <= '0;
                    frame_done_q <= (bcnt_q == 4'd6);
                end else if (TIMEOUT_CYCLES > 0 && tcnt_q == T_LAST) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else if (TIMEOUT_CYCLES > 0) begin
                    tcnt_q <= tcnt_q + TW'(1);
                end
            end
        end
    end
endmodule
